multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multi-cycle successor to the single-cycle combinational control unit. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, handshaking with instruction and data memories. Owns the instruction register and the per-state datapath enables. Decode supports R-type, I-type, load/store, NOP and HALT, with a parametrised memory-timeout error path. Sits between the memories and the datapath (regfile, ALU, PC).

Parameters:
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: OP_W].
OP_W, 5, opcode width; must be ≥5.
TIMEOUT, 15, max wait cycles for any memory ready; 0 disables timeout.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous, active-low reset.
imem_req  out  1  instruction fetch request, held until imem_ready.
imem_ready  in  1  fetch data valid this cycle.
instr_rdata  in  INSTR_W  fetched instruction.
dmem_req  out  1  data memory request, held until dmem_ready.
dmem_ready  in  1  data access complete this cycle.
instr  out  INSTR_W  current instruction register contents.
pc_en  out  1  one-cycle PC increment pulse.
alu_op  out  4  ALU operation: 0 add, 1 sub, 2 xor, 12 andn.
reg_dest  out  2  0 = I-type dest field, 2 = R-type dest field.
reg_write  out  1  register-file write strobe.
mem_read  out  1  data read (qualifies dmem_req).
mem_write  out  1  data write (qualifies dmem_req).
mem_to_reg  out  1  write-back source is memory.
halted  out  1  sticky after HALT.
err  out  1  sticky after memory timeout.

Behaviour:
- Reset (async, rst_n=0): state=FETCH, instr=0, wait counter=0, all outputs 0. Deassertion is synchronised externally; first active edge begins a fetch.
- Decode (combinational on instr):
  - opcode 11001 = R-type; funct = instr[1:0]; reg_dest=2.
  - opcode[4:3]=01 = I-type; funct = opcode[1:0]; reg_dest=0.
  - funct → alu_op: 00→0, 01→1, 10→2, 11→12.
  - 10001 = LD and 10000 = ST: alu_op=0 (address add), reg_dest=0.
  - 00000 = HALT; 00001 and all other opcodes = NOP.
- FETCH: imem_req=1. On imem_ready: instr←instr_rdata, pc_en=1 that cycle, → DECODE.
- DECODE: 1 cycle, → EXEC.
- EXEC: 1 cycle, alu_op valid. Next state: ALU ops→WB; LD/ST→MEM; NOP→FETCH; HALT→HALT.
- MEM: dmem_req=1, with mem_read (LD) or mem_write (ST) held. On dmem_ready: LD→WB; ST→FETCH.
- WB: reg_write=1 for exactly 1 cycle; mem_to_reg=1 only for LD; → FETCH.
- HALT: halted=1, no requests; exit only via reset.
- ERR: err=1, no requests; exit only via reset.
- alu_op and reg_dest are held stable from EXEC through WB.
- Latency (ready on first cycle): ALU 4 cycles, LD 5, ST 4, NOP 3, FETCH→FETCH.
- Timeout:
  - Wait counter clears on entry to FETCH/MEM and increments each cycle ready is low.
  - If the counter reaches TIMEOUT with ready still low → ERR.
  - Ready arriving in the same cycle the counter hits TIMEOUT wins (normal transition).
  - TIMEOUT=0 waits forever.
- instr is written only on an accepted fetch; imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- Reset asserted mid-MEM drops dmem_req/mem_write immediately (asynchronously).

Decomposition:
- Package ctrl_pkg:
  - Opcode constants: OP_RTYPE=11001, OP_LD, OP_ST, OP_HALT, OP_NOP.
  - ALU encodings: ALU_ADD=0, ALU_SUB=1, ALU_XOR=2, ALU_ANDN=12.
  - State enum: FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
  - Instruction-class enum.
- Sub-module instr_decode: purely combinational, instr → {class, alu_op, reg_dest}. The top holds the FSM, IR and wait counter.

Test Plan:
- R-type instr 0xC803 (opcode 11001, funct 11), imem_ready on first cycle → pc_en pulse in cycle 1; alu_op=12 and reg_dest=2 in EXEC; reg_write=1 exactly one cycle; back in FETCH 4 cycles after fetch start.
- I-type opcode 01001, then LD with dmem_ready delayed 3 cycles:
  - I-type → alu_op=1, reg_dest=0.
  - LD → mem_read/dmem_req held 4 cycles, then WB with mem_to_reg=1 and reg_write=1.
- ST, dmem_ready on first MEM cycle → mem_write=1 one cycle, no reg_write, returns to FETCH.
- TIMEOUT=15, imem_ready tied 0:
  - err rises after 15 waiting cycles; imem_req drops and stays low.
  - Repeat with ready arriving on cycle 15 → normal DECODE, err stays 0.
- HALT (instr 0x0000) → halted=1 after EXEC; no further imem_req for 50 cycles; rst_n pulse clears halted and restarts fetch.
- rst_n asserted mid-MEM (ST) → all outputs 0 in the same cycle without a clock edge; instr=0; FETCH resumes after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALU encodings, FSM states and instruction classes for the multi-cycle control unit.
package multicycle_control_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b11001;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_ANDN = 4'd12;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT, ERR} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_LD, CL_ST, CL_HALT, CL_NOP} iclass_t;
  function automatic logic [3:0] alu_of(input logic [1:0] f);
    return f == 2'd0 ? ALU_ADD : f == 2'd1 ? ALU_SUB : f == 2'd2 ? ALU_XOR : ALU_ANDN;
  endfunction
endpackage

// File: rtl/multicycle_control_instr_decode.sv
// multicycle_control_instr_decode: combinational opcode/funct decode into class, ALU op and destination select.
module multicycle_control_instr_decode
  import multicycle_control_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op,
  input  logic [1:0]      funct,
  output iclass_t         cls,
  output logic [3:0]      alu_op,
  output logic [1:0]      reg_dest
);
  logic rtype, itype;
  always_comb begin
    rtype    = op == OP_W'(OP_RTYPE);
    itype    = op[OP_W-1:3] == (OP_W-3)'(1);
    cls      = rtype || itype ? CL_ALU :
               op == OP_W'(OP_LD) ? CL_LD :
               op == OP_W'(OP_ST) ? CL_ST :
               op == OP_W'(OP_HALT) ? CL_HALT : CL_NOP;
    alu_op   = rtype ? alu_of(funct) : itype ? alu_of(op[1:0]) : ALU_ADD;
    reg_dest = rtype ? 2'd2 : 2'd0;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer with instruction register, memory handshakes and timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OP_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic               dmem_req,
  input  logic               dmem_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               pc_en,
  output logic [3:0]         alu_op,
  output logic [1:0]         reg_dest,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               halted,
  output logic               err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t         state;
  logic [CW-1:0]  cnt;
  iclass_t        cls;
  logic [3:0]     dec_alu;
  logic [1:0]     dec_dest;
  logic           tmo;
  assign tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT);
  multicycle_control_instr_decode #(.OP_W(OP_W)) u_dec (
    .op      (instr[INSTR_W-1 -: OP_W]),
    .funct   (instr[1:0]),
    .cls     (cls),
    .alu_op  (dec_alu),
    .reg_dest(dec_dest)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= FETCH;
      instr      <= '0;
      cnt        <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      pc_en      <= 1'b0;
      alu_op     <= '0;
      reg_dest   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      pc_en     <= 1'b0;
      reg_write <= 1'b0;
      case (state)
        // the first cycle out of reset only raises the request; ready is honoured once it is visible
        FETCH:
          if (!imem_req) begin
            imem_req <= 1'b1;
            cnt      <= '0;
          end else if (imem_ready) begin
            instr    <= instr_rdata;
            pc_en    <= 1'b1;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else if (tmo) begin
            imem_req <= 1'b0;
            err      <= 1'b1;
            state    <= ERR;
          end else
            cnt <= cnt + 1'b1;
        DECODE: begin
          alu_op   <= dec_alu;
          reg_dest <= dec_dest;
          state    <= EXEC;
        end
        EXEC:
          case (cls)
            CL_ALU: begin
              reg_write <= 1'b1;
              state     <= WB;
            end
            CL_LD, CL_ST: begin
              dmem_req  <= 1'b1;
              mem_read  <= cls == CL_LD;
              mem_write <= cls == CL_ST;
              cnt       <= '0;
              state     <= MEM;
            end
            CL_HALT: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: begin
              imem_req <= 1'b1;
              cnt      <= '0;
              state    <= FETCH;
            end
          endcase
        MEM:
          if (dmem_ready) begin
            dmem_req   <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= mem_read;
            mem_to_reg <= mem_read;
            imem_req   <= !mem_read;
            cnt        <= '0;
            state      <= mem_read ? WB : FETCH;
          end else if (tmo) begin
            dmem_req  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b1;
            state     <= ERR;
          end else
            cnt <= cnt + 1'b1;
        WB: begin
          mem_to_reg <= 1'b0;
          imem_req   <= 1'b1;
          cnt        <= '0;
          state      <= FETCH;
        end
        default: state <= state;
      endcase
    end
endmodule
